// File: rtl/seg7_pkg.sv
// Shared constants and the BCD/hex to active-low 7-segment encoding for the scan driver.
// The hex glyph set is selected by the caller (see SEG7_HEX_EN in seg7_decode).
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, 0 = segment lit
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [6:0] seg7_code(input logic [3:0] digit, input logic hex_en);
        logic [6:0] code;
        case (digit)
            4'h0:    code = SEG_0;
            4'h1:    code = SEG_1;
            4'h2:    code = SEG_2;
            4'h3:    code = SEG_3;
            4'h4:    code = SEG_4;
            4'h5:    code = SEG_5;
            4'h6:    code = SEG_6;
            4'h7:    code = SEG_7;
            4'h8:    code = SEG_8;
            4'h9:    code = SEG_9;
            4'hA:    code = hex_en ? SEG_A : SEG_BLANK;
            4'hB:    code = hex_en ? SEG_B : SEG_BLANK;
            4'hC:    code = hex_en ? SEG_C : SEG_BLANK;
            4'hD:    code = hex_en ? SEG_D : SEG_BLANK;
            4'hE:    code = hex_en ? SEG_E : SEG_BLANK;
            4'hF:    code = hex_en ? SEG_F : SEG_BLANK;
            default: code = SEG_BLANK;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit digit to active-low segment decoder.
// Define SEG7_HEX_EN to show A-F glyphs; otherwise codes 10-15 are blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

`ifdef SEG7_HEX_EN
    localparam logic HEX_EN = 1'b1;
`else
    localparam logic HEX_EN = 1'b0;
`endif

    // Pure table lookup
    always_comb begin
        seg = seg7_code(digit, HEX_EN);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit common-anode 7-segment driver with leading-zero blanking and
// a per-slot all-off guard window. Hex glyphs are enabled by the SEG7_HEX_EN macro.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic                    load,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [4*NUM_DIGITS-1:0] shadow_r;
    logic [CNT_W-1:0]        cnt_r;
    logic [IDX_W-1:0]        idx_r;

    logic                    cnt_wrap_s;
    logic                    in_guard_s;
    logic [3:0]              digit_s;
    logic                    digit_lz_s;
    logic [NUM_DIGITS-1:0]   lz_mask_s;
    logic [6:0]              code_s;
    logic [6:0]              seg_next_s;
    logic [NUM_DIGITS-1:0]   an_next_s;

    assign cnt_wrap_s = (cnt_r == CNT_W'(REFRESH_DIV - 1));
    assign in_guard_s = ({1'b0, cnt_r} < (CNT_W + 1)'(GUARD_CYCLES));

    // Shadow capture, slot counter and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_r <= '0;
            cnt_r    <= '0;
            idx_r    <= '0;
        end else begin
            if (load) begin
                shadow_r <= bcd_in;
            end else begin
                shadow_r <= shadow_r;
            end
            if (cnt_wrap_s) begin
                cnt_r <= '0;
                idx_r <= (idx_r == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_r + IDX_W'(1);
            end else begin
                cnt_r <= cnt_r + CNT_W'(1);
                idx_r <= idx_r;
            end
        end
    end

    // Digit k is a leading zero when it and every digit above it are zero; digit 0 never is
    always_comb begin
        logic all_zero;
        all_zero  = 1'b1;
        lz_mask_s = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            all_zero     = all_zero & (shadow_r[4*k +: 4] == 4'h0);
            lz_mask_s[k] = all_zero & (k != 0);
        end
    end

    // Select the active digit, its blanking flag and its anode
    always_comb begin
        digit_s    = 4'h0;
        digit_lz_s = 1'b0;
        an_next_s  = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_r == IDX_W'(k)) begin
                digit_s      = shadow_r[4*k +: 4];
                digit_lz_s   = lz_mask_s[k];
                an_next_s[k] = in_guard_s;
            end else begin
                an_next_s[k] = 1'b1;
            end
        end
    end

    seg7_decode u_decode (
        .digit (digit_s),
        .seg   (code_s)
    );

    // Blanked leading zeros keep their anode asserted; only the segments go dark
    always_comb begin
        seg_next_s = code_s;
        if (in_guard_s) begin
            seg_next_s = SEG_BLANK;
        end else if (blank_lz && digit_lz_s) begin
            seg_next_s = SEG_BLANK;
        end else begin
            seg_next_s = code_s;
        end
    end

    // Registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else begin
            seg <= seg_next_s;
            an  <= an_next_s;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench for seg7_scan_driver (4 digits, 8-cycle slots, 2-cycle guard).
// A time-based display model predicts seg/an every cycle; literal checks pin the model.
module tb_seg7_scan_driver;

    localparam int ND = 4;
    localparam int RD = 8;
    localparam int GC = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bcd_in = 16'h0000;
    logic        load = 1'b0;
    logic        blank_lz = 1'b0;
    logic [6:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int failures = 0;

    seg7_scan_driver #(.NUM_DIGITS(ND), .REFRESH_DIV(RD), .GUARD_CYCLES(GC)) dut (
        .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
        .blank_lz(blank_lz), .seg(seg), .an(an)
    );

    always #5 clk = ~clk;

    localparam logic [6:0] TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000,
`ifdef SEG7_HEX_EN
        7'b0001000, 7'b0000011, 7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
`else
        7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F
`endif
    };

    // Display at the edge following t cycles since reset release
    function automatic logic [10:0] model_out(input int t, input logic [15:0] sh, input logic lz);
        int k;
        logic [6:0] s;
        logic [3:0] a;
        if ((t % RD) < GC) return {7'h7F, 4'hF};
        k = (t / RD) % ND;
        a = 4'hF;
        a[k] = 1'b0;
        if (lz && k != 0 && (sh >> (4 * k)) == 16'h0000) s = 7'h7F;
        else s = TAB[sh[4*k +: 4]];
        return {s, a};
    endfunction

    int          m_ticks;
    logic [15:0] m_shadow;
    logic [6:0]  exp_seg;
    logic [3:0]  exp_an;

    // Reference model state
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ticks  <= 0;
            m_shadow <= 16'h0000;
            exp_seg  <= 7'h7F;
            exp_an   <= 4'hF;
        end else begin
            {exp_seg, exp_an} <= model_out(m_ticks, m_shadow, blank_lz);
            if (load) m_shadow <= bcd_in;
            m_ticks <= m_ticks + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        checks++;
        if (seg !== exp_seg || an !== exp_an) begin
            failures++;
            $display("FAIL model t=%0t seg=%b an=%b expected seg=%b an=%b",
                     $time, seg, an, exp_seg, exp_an);
        end
    end

    task automatic check_lit(input string name, input logic [10:0] act, input logic [10:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic wait_an(input logic [3:0] target);
        int n;
        n = 0;
        @(negedge clk);
        while (an !== target && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (an !== target) begin
            checks++;
            failures++;
            $display("FAIL wait_an timeout actual=%b required=%b", an, target);
        end
    endtask

    task automatic do_load(input logic [15:0] v, input logic lz);
        @(negedge clk);
        bcd_in = v;
        blank_lz = lz;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic slot_check(input string name, input logic [3:0] a, input logic [6:0] s);
        wait_an(a);
        check_lit(name, {seg, an}, {s, a});
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_lit("reset_hold", {seg, an}, {7'h7F, 4'hF});
        rst_n = 1'b1;
        // Release timing: anodes first enabled after the third edge
        repeat (2) @(posedge clk);
        #1 check_lit("rel_edge2", {7'h00, an}, {7'h00, 4'hF});
        @(posedge clk);
        #1 check_lit("rel_edge3", {seg, an}, {7'b1000000, 4'b1110});
        repeat (5) @(posedge clk);
        #1 check_lit("rel_edge8", {7'h00, an}, {7'h00, 4'b1110});
        @(posedge clk);
        #1 check_lit("rel_edge9", {seg, an}, {7'h7F, 4'hF});
        repeat (2) @(posedge clk);
        #1 check_lit("rel_edge11", {7'h00, an}, {7'h00, 4'b1101});

        do_load(16'h1234, 1'b0);
        slot_check("d0_1234", 4'b1110, 7'b0011001);
        slot_check("d1_1234", 4'b1101, 7'b0110000);
        slot_check("d2_1234", 4'b1011, 7'b0100100);
        slot_check("d3_1234", 4'b0111, 7'b1111001);

        do_load(16'h0070, 1'b1);
        slot_check("d3_0070", 4'b0111, 7'h7F);
        slot_check("d0_0070", 4'b1110, 7'b1000000);
        slot_check("d1_0070", 4'b1101, 7'b1111000);
        slot_check("d2_0070", 4'b1011, 7'h7F);

        do_load(16'h0000, 1'b1);
        slot_check("d1_0000", 4'b1101, 7'h7F);
        slot_check("d0_0000", 4'b1110, 7'b1000000);

        do_load(16'h00A5, 1'b1);
        slot_check("d0_00A5", 4'b1110, 7'b0010010);
`ifdef SEG7_HEX_EN
        slot_check("d1_00A5", 4'b1101, 7'b0001000);
`else
        slot_check("d1_00A5", 4'b1101, 7'h7F);
`endif
        slot_check("d2_00A5", 4'b1011, 7'h7F);

        // Load coinciding with the slot-wrap edge
        @(negedge clk);
        while ((m_ticks % RD) != RD - 1) @(negedge clk);
        bcd_in = 16'h9999;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        check_lit("wrap_load_seg", {seg, 4'h0}, {7'b0010000, 4'h0});

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            blank_lz = 1'($urandom_range(0, 1));
            load = ($urandom_range(0, 7) == 0);
            bcd_in = 16'($urandom);
            if ($urandom_range(0, 3) != 0) bcd_in[15:12] = 4'h0;
            if ($urandom_range(0, 2) == 0) bcd_in[11:8] = 4'h0;
            if (i == 1500) begin
                // Mid-scan asynchronous reset
                #2 rst_n = 1'b0;
                #1 check_lit("midscan_reset", {seg, an}, {7'h7F, 4'hF});
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        load = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
